// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of the UART receive FIFO.
// The FIFO is the slave. The byte consumer is the master.
interface uart_rx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic               rd_en;
  logic [7:0]         rd_data;
  logic               rd_valid;
  logic [FIFO_AW:0]   fifo_count;

  modport master (output rd_en, input rd_data, rd_valid, fifo_count);
  modport slave  (input rd_en, output rd_data, rd_valid, fifo_count);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// The line is oversampled on sys_clk through a 2-flop synchronizer.
// The receiver flags stop-bit framing errors and FIFO overflow.
module uart_rx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          uart_rxd,
  uart_rx_fifo_if.slave rd_if,
  input  logic          ovf_clr,
  output logic          frame_err,
  output logic          overflow,
  output logic          rx_busy
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [FIFO_AW:0]   CNT_MAX  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // Receiver state
  logic             rx_meta_q, rxs_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             ferr_q, ferr_d;
  logic             push;

  // FIFO state
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               rd_valid, pop, full, wr, drop;

  // Two-flop synchronizer. It idles high so that reset does not look like a start bit.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (sys_rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receiver state register and datapath flops
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

  // Receiver next-state logic. It decides the start glitch, shifts data LSB first, and checks the stop bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control. A pop frees a slot in the same cycle, so a push while full still succeeds when a pop accompanies it.
  always_comb begin
    rd_valid = (count_q != '0);
    pop      = rd_if.rd_en & rd_valid;
    full     = (count_q == CNT_MAX);
    wr       = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr  ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
    else if (!wr && pop) count_d = count_q - (FIFO_AW + 1)'(1);
    // If a drop and a clear arrive together, the drop wins.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage
  always_ff @(posedge sys_clk) begin
    // NOTE: storage has no reset. Stale entries are unreachable because rd_data is masked while the FIFO is empty.
    if (wr) mem[wr_ptr_q] <= shift_q;
  end

  assign rd_if.rd_data    = rd_valid ? mem[rd_ptr_q] : 8'h00;
  assign rd_if.rd_valid   = rd_valid;
  assign rd_if.fifo_count = count_q;
  assign frame_err        = ferr_q;
  assign overflow         = ovf_q;
  assign rx_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic.
// Results are compared against a queue-based byte model.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int FIFO_AW  = 2;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
  localparam int DEPTH    = 2 ** FIFO_AW;
  localparam int LATENCY  = 2 + HALF + 9 * DIV + 1;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic uart_rxd = 1'b1;
  logic ovf_clr = 1'b0;
  logic frame_err, overflow, rx_busy;

  uart_rx_fifo_if #(.FIFO_AW(FIFO_AW)) rd_if ();

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(FIFO_AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .rd_if     (rd_if),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err),
    .overflow  (overflow),
    .rx_busy   (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_count = 0;
  int rv_rise_cyc = -1;
  logic rv_prev = 1'b0;
  int t_fall = 0;

  // Reference model: the received bytes in arrival order plus the overflow flag
  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;

  // The monitor counts cycles, frame_err pulses and rd_valid rising edges. It samples 1 time unit after each edge.
  always begin
    @(posedge sys_clk);
    cyc++;
    #1;
    if (frame_err === 1'b1) fe_count++;
    if (rd_if.rd_valid === 1'b1 && !rv_prev) rv_rise_cyc = cyc;
    rv_prev = (rd_if.rd_valid === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drives one 8N1 frame starting at a negedge. The line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    t_fall = cyc;
    uart_rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(DIV);
    end
    uart_rxd = stop_bit;
    tick(DIV);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp_b;
    check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
    exp_b = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
    check({tag, "_data"}, 32'(rd_if.rd_data), 32'(exp_b));
    rd_if.rd_en = 1'b1;
    tick(1);
    rd_if.rd_en = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1);
    tick(2);
    model_push(b);
  endtask

  initial begin
    int fe_base;
    int n;
    int lat;
    logic [7:0] b;
    logic bad;
    rd_if.rd_en = 1'b0;

    // Reset state
    tick(3);
    sys_rst = 1'b0;
    tick(1);
    check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_count", 32'(rd_if.fifo_count), 32'd0);
    check("rst_data", 32'(rd_if.rd_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    tick(5);

    // 1: single byte, latency, then pop
    fe_base = fe_count;
    rv_rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    tick(2);
    model_push(8'hA5);
    lat = rv_rise_cyc - t_fall;
    check("t1_latency_in_window", 32'((lat >= LATENCY - 1) && (lat <= LATENCY + 1)), 32'd1);
    check("t1_count", 32'(rd_if.fifo_count), 32'd1);
    check("t1_no_ferr", 32'(fe_count - fe_base), 32'd0);
    pop_check("t1_pop");
    check("t1_valid_after", 32'(rd_if.rd_valid), 32'd0);
    check("t1_count_after", 32'(rd_if.fifo_count), 32'd0);

    // 2: short low glitch is rejected
    fe_base = fe_count;
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    check("t2_busy_on_glitch", 32'(rx_busy), 32'd1);
    n = 0;
    while (rx_busy && n < 11) begin
      tick(1);
      n++;
    end
    check("t2_back_idle", 32'(rx_busy), 32'd0);
    tick(200);
    check("t2_count", 32'(rd_if.fifo_count), 32'd0);
    check("t2_no_ferr", 32'(fe_count - fe_base), 32'd0);

    // 3: framing error with held-low break, then a clean byte
    fe_base = fe_count;
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("t3_one_ferr", 32'(fe_count - fe_base), 32'd1);
    check("t3_count", 32'(rd_if.fifo_count), 32'd0);
    check("t3_busy_in_break", 32'(rx_busy), 32'd1);
    uart_rxd = 1'b1;
    tick(5);
    check("t3_idle_after_break", 32'(rx_busy), 32'd0);
    send_good(8'h81);
    check("t3_count_81", 32'(rd_if.fifo_count), 32'd1);
    pop_check("t3_pop");
    check("t3_still_one_ferr", 32'(fe_count - fe_base), 32'd1);

    // 4: overflow on the fifth byte
    for (int i = 1; i <= 5; i++) send_good(8'(i));
    check("t4_count", 32'(rd_if.fifo_count), 32'(DEPTH));
    check("t4_ovf", 32'(overflow), 32'(model_ovf));
    for (int i = 0; i < DEPTH; i++) pop_check("t4_pop");
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // 5: pop in the stop-sample cycle of a push into a full FIFO
    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    send_good(8'h44);
    check("t5_full", 32'(rd_if.fifo_count), 32'(DEPTH));
    fork
      send_frame(8'h55, 1'b1);
      begin
        tick(LATENCY - 1);
        check("t5_head_at_pop", 32'(rd_if.rd_data), 32'(model_q[0]));
        rd_if.rd_en = 1'b1;
        tick(1);
        rd_if.rd_en = 1'b0;
      end
    join
    tick(2);
    void'(model_q.pop_front());
    model_q.push_back(8'h55);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    check("t5_count", 32'(rd_if.fifo_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop_check("t5_pop");

    // Randomized traffic with occasional bad stop bits, random pops and random clears
    for (int it = 0; it < 12; it++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      fe_base = fe_count;
      send_frame(b, ~bad);
      uart_rxd = 1'b1;
      tick(4 + $urandom_range(0, 6));
      if (!bad) model_push(b);
      check("rnd_ferr", 32'(fe_count - fe_base), 32'(bad));
      check("rnd_count", 32'(rd_if.fifo_count), 32'(model_q.size()));
      check("rnd_ovf", 32'(overflow), 32'(model_ovf));
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) if (model_q.size() > 0) pop_check("rnd_pop");
      if ($urandom_range(0, 3) == 0) begin
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        model_ovf = 1'b0;
        check("rnd_ovf_clr", 32'(overflow), 32'd0);
      end
    end

    // 6: reset in the middle of 0xFF data bits, then 0x5A
    send_good(8'h77);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(4 * DIV + 5);
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        check("t6_rst_valid", 32'(rd_if.rd_valid), 32'd0);
        check("t6_rst_count", 32'(rd_if.fifo_count), 32'd0);
        check("t6_rst_busy", 32'(rx_busy), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        check("t6_rst_data", 32'(rd_if.rd_data), 32'd0);
      end
    join
    model_q.delete();
    model_ovf = 1'b0;
    tick(5);
    fe_base = fe_count;
    send_good(8'h5A);
    check("t6_count", 32'(rd_if.fifo_count), 32'd1);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_no_ferr", 32'(fe_count - fe_base), 32'd0);
    pop_check("t6_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
